// File: rtl/kbd_entry_ctrl_pkg.sv
// Shared keypad scan codes, FSM state type and key classifiers.
// Imported by the keypad entry controller and its event detector.
package kbd_entry_ctrl_pkg;

   localparam logic [7:0] KP_0            = 8'h70;
   localparam logic [7:0] KP_1            = 8'h69;
   localparam logic [7:0] KP_2            = 8'h72;
   localparam logic [7:0] KP_3            = 8'h7A;
   localparam logic [7:0] KP_4            = 8'h6B;
   localparam logic [7:0] KP_5            = 8'h73;
   localparam logic [7:0] KP_6            = 8'h74;
   localparam logic [7:0] KP_7            = 8'h6C;
   localparam logic [7:0] KP_8            = 8'h75;
   localparam logic [7:0] KP_9            = 8'h7D;
   localparam logic [7:0] KP_STAR         = 8'h7C;
   localparam logic [7:0] KP_MINUS        = 8'h7B;
   localparam logic [7:0] KP_KEY_RELEASED = 8'hF0;
   localparam logic [7:0] KP_INVALID      = 8'hFF;

   localparam logic [3:0] BLANK_BCD = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      SETTLE,
      FLUSH
   } state_t;

   function automatic logic is_digit(input logic [7:0] k);
      logic r;
      r = 1'b0;
      case (k)
         KP_0, KP_1, KP_2, KP_3, KP_4,
         KP_5, KP_6, KP_7, KP_8, KP_9: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_cmd(input logic [7:0] k);
      return (k == KP_STAR) || (k == KP_MINUS);
   endfunction

endpackage

// File: rtl/kbd_event_detect.sv
// Turns release sequences (F0 then code) into one pending key event.
// Ports: clk, reset, key in; consume in; ev_fire, ev_valid, ev_code out.
module kbd_event_detect
   import kbd_entry_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] key,
   input  logic       consume,
   output logic       ev_fire,
   output logic       ev_valid,
   output logic [7:0] ev_code
);

   logic [7:0] key_d;
   logic       pending;

   // Fires on the code that follows a release marker, so a repeated
   // key still produces one event per keystroke.
   assign ev_fire = (key_d == KP_KEY_RELEASED) && (key != key_d)
                  && (is_digit(key) || is_cmd(key));

   assign ev_valid = pending;

   always_ff @(posedge clk) begin
      if (reset) begin
         key_d   <= KP_KEY_RELEASED;
         pending <= 1'b0;
         ev_code <= KP_KEY_RELEASED;
      end else begin
         key_d <= key;
         // A fresh event wins over a consume in the same cycle.
         if (ev_fire) begin
            pending <= 1'b1;
            ev_code <= key;
         end else if (consume) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/kbd_entry_ctrl.sv
// Keypad entry controller: shifts digits, commits alarm/time entries.
// Ports: clk, reset, key, key_buffer in; kbd_shift, set_alarm, set_time,
// entry_value, digit_count, entry_error, entry_timeout out.
module kbd_entry_ctrl
   import kbd_entry_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
   parameter int unsigned FLUSH_LEN      = 4
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  key,
   input  logic [15:0] key_buffer,
   output logic        kbd_shift,
   output logic        set_alarm,
   output logic        set_time,
   output logic [15:0] entry_value,
   output logic [2:0]  digit_count,
   output logic        entry_error,
   output logic        entry_timeout
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int FW = $clog2(FLUSH_LEN + 1);
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [FW-1:0] F_MAX = FW'(FLUSH_LEN - 1);

   state_t        state, state_n;
   logic          ev_fire, ev_valid, consume;
   logic [7:0]    ev_code;
   logic [TW-1:0] timer;
   logic [FW-1:0] flush_cnt;
   logic          inc_digit, clr_digit, commit;
   logic          alarm_n, time_n, err_n;
   logic          to_hit;

   kbd_event_detect u_det (
      .clk      (clk),
      .reset    (reset),
      .key      (key),
      .consume  (consume),
      .ev_fire  (ev_fire),
      .ev_valid (ev_valid),
      .ev_code  (ev_code)
   );

   always_comb begin
      state_n   = state;
      consume   = 1'b0;
      kbd_shift = 1'b0;
      inc_digit = 1'b0;
      clr_digit = 1'b0;
      commit    = 1'b0;
      alarm_n   = 1'b0;
      time_n    = 1'b0;
      err_n     = 1'b0;
      case (state)
         IDLE: begin
            if (ev_valid) begin
               consume = 1'b1;
               if (is_digit(ev_code)) begin
                  inc_digit = 1'b1;
                  state_n   = SHIFT;
               end else if (digit_count == 3'd4) begin
                  commit    = 1'b1;
                  alarm_n   = (ev_code == KP_STAR);
                  time_n    = (ev_code == KP_MINUS);
                  clr_digit = 1'b1;
                  state_n   = FLUSH;
               end else begin
                  err_n     = 1'b1;
                  clr_digit = 1'b1;
                  state_n   = FLUSH;
               end
            end
         end
         SHIFT: begin
            kbd_shift = 1'b1;
            state_n   = SETTLE;
         end
         SETTLE: state_n = IDLE;
         FLUSH: begin
            // key is frozen at the command code, so each shift adds 4'hF.
            kbd_shift = 1'b1;
            if (flush_cnt == F_MAX) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // An event in the same cycle suppresses the timeout.
   assign to_hit = !ev_fire && (timer == T_MAX)
                 && (digit_count != 3'd0) && (digit_count != 3'd4);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         flush_cnt     <= '0;
         timer         <= '0;
         digit_count   <= 3'd0;
         entry_value   <= 16'h0000;
         set_alarm     <= 1'b0;
         set_time      <= 1'b0;
         entry_error   <= 1'b0;
         entry_timeout <= 1'b0;
      end else begin
         state         <= state_n;
         flush_cnt     <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
         set_alarm     <= alarm_n;
         set_time      <= time_n;
         entry_error   <= err_n;
         entry_timeout <= to_hit;
         if (commit) entry_value <= key_buffer;
         // Saturating timer; cleared by every keystroke.
         if (ev_fire)           timer <= '0;
         else if (timer != T_MAX) timer <= timer + 1'b1;
         // Saturates at 4 so the buffer keeps the newest four digits.
         if (clr_digit)                          digit_count <= 3'd0;
         else if (inc_digit && digit_count != 3'd4) digit_count <= digit_count + 3'd1;
         else if (to_hit)                        digit_count <= 3'd0;
      end
   end

endmodule
